sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Single-clock first-in/first-out buffer for small data words (4-bit by default).
//   A producer writes with push and a consumer reads with pop.
//   fifo_full / fifo_empty status flags give back-pressure to both sides.
//   General-purpose rate-decoupling buffer between two blocks in the same clock domain.
// PARAMETERS
//   WIDTH  4  data word width in bits
//   DEPTH  8  number of storage entries; power of two, >= 2
//   AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//   clk         in   1      rising-edge clock; single clock domain
//   reset       in   1      synchronous, active-high reset (sampled on rising clk)
//   data_in     in   WIDTH  write data, sampled on rising clk when push accepted
//   push        in   1      write request
//   pop         in   1      read request
//   data_out    out  WIDTH  registered read data
//   fifo_full   out  1      high when DEPTH entries are stored
//   fifo_empty  out  1      high when 0 entries are stored
// BEHAVIOUR
//   - Reset (reset=1 at rising clk): wr_ptr=0, rd_ptr=0, count=0, data_out=0,
//     fifo_empty=1, fifo_full=0. Memory contents are not cleared.
//   - Reset overrides push/pop in the same cycle.
//   - Reset mid-operation discards all stored data.
//   - Storage: DEPTH x WIDTH register array.
//   - Pointers: AW-bit wr_ptr/rd_ptr wrap from DEPTH-1 to 0.
//   - Occupancy: count is AW+1 bits, range 0..DEPTH.
//   - Flags: combinational from count; fifo_empty = (count==0), fifo_full = (count==DEPTH).
//     Flags reflect the state after the last clock edge.
//   - Push is accepted when push=1 and (fifo_full=0, or pop is also accepted this cycle).
//     On accept: mem[wr_ptr] <= data_in, then wr_ptr++.
//   - Pop is accepted when pop=1 and fifo_empty=0.
//     On accept: data_out <= mem[rd_ptr], then rd_ptr++.
//     Latency: the word appears on data_out after the same rising edge and holds until the next accepted pop.
//   - Rejected push (full, no accepted pop): ignored; no state change, no error flag.
//   - Rejected pop (empty): ignored; data_out keeps its previous value.
//   - Simultaneous push+pop:
//     - not empty: both accepted, count unchanged, and at DEPTH the write goes into the slot freed by the read.
//     - empty: only the push is accepted; no read-through to data_out.
//   - Count update: +1 push only, -1 pop only, 0 both or neither.
//   - push/pop with X/unknown values before the first reset release must not corrupt state while reset=1.
//   - No other outputs. Fully synchronous, no latches.
// TESTING
//   1. Reset held 1 cycle -> fifo_empty=1, fifo_full=0, data_out=0.
//   2. Push 4'h2, push 4'h4, pop -> data_out=4'h2; fifo_empty=0 (1 entry left).
//   3. Continuing: push 4'h5, 4'h6, 4'hC, pop -> data_out=4'h4; next pop -> 4'h5.
//      Remaining count = 2.
//   4. Push DEPTH words 0..7 -> fifo_full=1 after the 8th.
//      A 9th push (4'hF) is ignored.
//      Pop x8 -> 0..7 in order, then fifo_empty=1.
//      A further pop leaves data_out=4'h7.
//   5. Full, push 4'hA + pop together -> data_out=oldest word, fifo_full stays 1.
//      Then drain -> 4'hA arrives last.
//      Empty, push+pop together -> count=1, data_out unchanged.
//   6. Wrap/reset: run 20 push/pop cycles with pointers wrapping; order preserved.
//      Assert reset with 3 entries stored -> fifo_empty=1, data_out=0 next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and combinational full/empty flags.
// A push into a full FIFO is accepted when a pop is accepted in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t count_q, count_d;
  logic push_ok, pop_ok;

  assign fifo_empty = (count_q == cnt_t'(0));
  assign fifo_full  = (count_q == cnt_t'(DEPTH));

  assign pop_ok  = pop && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_out <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage is never cleared; reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               full;
    bit               empty;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_out;
  int               tests;
  int               fails;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .push      (push),
    .pop       (pop),
    .data_out  (data_out),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus and record what the FIFO must show after the next edge.
  task automatic step(input bit rst, input bit ps, input bit pp, input logic [WIDTH-1:0] d);
    bit   pop_acc;
    bit   push_acc;
    exp_t e;
    @(negedge clk);
    reset   = rst;
    push    = ps;
    pop     = pp;
    data_in = d;
    if (rst) begin
      model_q.delete();
      model_out = '0;
    end else begin
      pop_acc  = pp && (model_q.size() > 0);
      push_acc = ps && ((model_q.size() < DEPTH) || pop_acc);
      if (pop_acc) model_out = model_q.pop_front();
      if (push_acc) model_q.push_back(d);
    end
    e.data  = model_out;
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (data_out !== e.data) begin
          fails++;
          $display("FAIL data_out: got %h expected %h at %0t", data_out, e.data, $time);
        end
        tests++;
        if (fifo_full !== e.full) begin
          fails++;
          $display("FAIL fifo_full: got %b expected %b at %0t", fifo_full, e.full, $time);
        end
        tests++;
        if (fifo_empty !== e.empty) begin
          fails++;
          $display("FAIL fifo_empty: got %b expected %b at %0t", fifo_empty, e.empty, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    tests     = 0;
    fails     = 0;
    model_out = '0;
    // Unknown request lines while reset is held must not disturb state.
    reset   = 1'b1;
    push    = 1'bx;
    pop     = 1'bx;
    data_in = 'x;

    step(1'b1, 1'b0, 1'b0, '0);

    do_push(4'h2);
    do_push(4'h4);
    do_pop();

    do_push(4'h5);
    do_push(4'h6);
    do_push(4'hC);
    do_pop();
    do_pop();
    do_pop();
    do_pop();
    do_pop();

    for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(i));
    do_push(4'hF);
    for (int i = 0; i < DEPTH; i++) do_pop();
    do_pop();

    for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(i + 3));
    step(1'b0, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < DEPTH; i++) do_pop();
    step(1'b0, 1'b1, 1'b1, 4'h9);
    do_pop();

    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, (i > 1), WIDTH'($urandom_range(0, 15)));
    do_push(4'h1);
    do_push(4'h2);
    do_push(4'h3);
    step(1'b1, 1'b1, 1'b1, 4'h7);
    do_pop();
    do_push(4'hE);
    do_pop();

    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) >= bias - 10),
           WIDTH'($urandom_range(0, 15)));
    end

    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
